// File: rtl/uart_pkg.sv
// Shared UART definitions: baud/parity codes, rx states and
// the oversample divisor helper used by the receive path.
package uart_pkg;

    localparam int unsigned OVERSAMPLE = 16;

    typedef enum logic [1:0] {
        BAUD_2400  = 2'b00,
        BAUD_4800  = 2'b01,
        BAUD_9600  = 2'b10,
        BAUD_19200 = 2'b11
    } baud_e;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_ODD  = 2'b01;
    localparam logic [1:0] PAR_EVEN = 2'b10;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_e;

    function automatic int unsigned baud_of(input logic [1:0] code);
        int unsigned b;
        b = 2400;
        if (code == BAUD_4800)  b = 4800;
        if (code == BAUD_9600)  b = 9600;
        if (code == BAUD_19200) b = 19200;
        return b;
    endfunction

    function automatic int unsigned div_of(input int unsigned clk_hz,
                                           input logic [1:0] code);
        return clk_hz / (baud_of(code) * OVERSAMPLE);
    endfunction

    // Code 11 shares the "no parity bit" meaning with 00.
    function automatic logic par_en(input logic [1:0] pt);
        return !(pt == PAR_NONE || pt == (PAR_ODD | PAR_EVEN));
    endfunction

endpackage

// File: rtl/uart_rx_sipo_if.sv
// Serial line, config and received-byte bundle of the UART receiver.
// The slave side is the receiver; the master side drives the line.
interface uart_rx_sipo_if;

    logic       data_rx;
    logic [1:0] baud_rate;
    logic [1:0] parity_type;
    logic [7:0] data_out;
    logic       done_flag;
    logic       active_flag;
    logic       parity_error;
    logic       stop_error;

    modport master (
        output data_rx, baud_rate, parity_type,
        input  data_out, done_flag, active_flag,
        input  parity_error, stop_error
    );

    modport slave (
        input  data_rx, baud_rate, parity_type,
        output data_out, done_flag, active_flag,
        output parity_error, stop_error
    );

endinterface

// File: rtl/rx_os_tick.sv
// 16x oversample prescaler: one-clock tick every DIV clocks,
// held at zero while restart is high.
module rx_os_tick
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ = 50000000
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [1:0] baud_sel,
    input  logic       restart,
    output logic       tick
);

    localparam logic [15:0] DIV0 = 16'(div_of(CLK_FREQ, 2'b00));
    localparam logic [15:0] DIV1 = 16'(div_of(CLK_FREQ, 2'b01));
    localparam logic [15:0] DIV2 = 16'(div_of(CLK_FREQ, 2'b10));
    localparam logic [15:0] DIV3 = 16'(div_of(CLK_FREQ, 2'b11));

    logic [15:0] lim;
    logic [15:0] cnt_q, cnt_d;

    always_comb begin
        lim = DIV0 - 16'd1;
        unique case (baud_sel)
            2'b00: lim = DIV0 - 16'd1;
            2'b01: lim = DIV1 - 16'd1;
            2'b10: lim = DIV2 - 16'd1;
            2'b11: lim = DIV3 - 16'd1;
        endcase
    end

    assign tick = !restart && (cnt_q == lim);

    always_comb begin
        cnt_d = cnt_q + 16'd1;
        if (restart || tick) cnt_d = '0;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) cnt_q <= '0;
        else          cnt_q <= cnt_d;
    end

endmodule

// File: rtl/uart_rx_sipo.sv
// UART receiver: synchronise line, find start bit mid-point,
// shift 8 bits LSB first, check parity/stop, pulse done.
module uart_rx_sipo
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 50000000,
    parameter int unsigned OVERSAMPLE = 16
) (
    input logic           clock,
    input logic           reset_n,
    uart_rx_sipo_if.slave bus
);

    localparam logic [3:0] MID  = 4'(OVERSAMPLE / 2 - 1);
    localparam logic [3:0] LAST = 4'(OVERSAMPLE - 1);

    logic      s1_q, rxs_q;
    rx_state_e state_q, state_d;
    logic [1:0] baud_q, baud_d, par_q, par_d;
    logic [3:0] tcnt_q, tcnt_d;
    logic [2:0] bcnt_q, bcnt_d;
    logic [7:0] sh_q, sh_d, dout_q, dout_d;
    logic pbad_q, pbad_d, done_q, done_d;
    logic perr_q, perr_d, serr_q, serr_d;
    logic armed_q, armed_d;
    logic tick, mid, full, restart, start_det, fin, active;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            s1_q  <= 1'b1;
            rxs_q <= 1'b1;
        end else begin
            s1_q  <= bus.data_rx;
            rxs_q <= s1_q;
        end
    end

    rx_os_tick #(.CLK_FREQ(CLK_FREQ)) u_tick (
        .clock    (clock),
        .reset_n  (reset_n),
        .baud_sel (baud_q),
        .restart  (restart),
        .tick     (tick)
    );

    assign mid  = tick && (tcnt_q == MID);
    assign full = tick && (tcnt_q == LAST);
    // A held-low line after a bad stop must go high before re-arming.
    assign start_det = (state_q == RX_IDLE) && !rxs_q && armed_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state_q <= RX_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RX_IDLE:   if (start_det) state_d = RX_START;
            RX_START:  if (mid) state_d = rxs_q ? RX_IDLE : RX_DATA;
            RX_DATA:
                if (full && bcnt_q == 3'd7)
                    state_d = par_en(par_q) ? RX_PARITY : RX_STOP;
            RX_PARITY: if (full) state_d = RX_STOP;
            RX_STOP:   if (full) state_d = RX_IDLE;
            default:   state_d = RX_IDLE;
        endcase
    end

    always_comb begin
        active  = (state_q != RX_IDLE);
        restart = (state_q == RX_IDLE);
        fin     = (state_q == RX_STOP) && full;
    end

    always_comb begin
        baud_d  = baud_q;
        par_d   = par_q;
        tcnt_d  = tick ? tcnt_q + 4'd1 : tcnt_q;
        bcnt_d  = bcnt_q;
        sh_d    = sh_q;
        pbad_d  = pbad_q;
        dout_d  = dout_q;
        perr_d  = perr_q;
        serr_d  = serr_q;
        done_d  = fin;
        armed_d = rxs_q ? 1'b1 : (fin ? 1'b0 : armed_q);
        if (start_det) begin
            baud_d = bus.baud_rate;
            par_d  = bus.parity_type;
        end
        if (restart || (state_q == RX_START && mid)) tcnt_d = '0;
        if (state_q == RX_START && mid) begin
            bcnt_d = '0;
            pbad_d = 1'b0;
        end
        if (state_q == RX_DATA && full) begin
            sh_d   = {rxs_q, sh_q[7:1]};
            bcnt_d = bcnt_q + 3'd1;
        end
        if (state_q == RX_PARITY && full)
            pbad_d = rxs_q ^ (^sh_q) ^ (par_q == PAR_ODD);
        if (fin) begin
            dout_d = sh_q;
            perr_d = pbad_q;
            serr_d = ~rxs_q;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            baud_q  <= '0;
            par_q   <= '0;
            tcnt_q  <= '0;
            bcnt_q  <= '0;
            sh_q    <= '0;
            pbad_q  <= 1'b0;
            dout_q  <= '0;
            perr_q  <= 1'b0;
            serr_q  <= 1'b0;
            done_q  <= 1'b0;
            armed_q <= 1'b1;
        end else begin
            baud_q  <= baud_d;
            par_q   <= par_d;
            tcnt_q  <= tcnt_d;
            bcnt_q  <= bcnt_d;
            sh_q    <= sh_d;
            pbad_q  <= pbad_d;
            dout_q  <= dout_d;
            perr_q  <= perr_d;
            serr_q  <= serr_d;
            done_q  <= done_d;
            armed_q <= armed_d;
        end
    end

    assign bus.data_out     = dout_q;
    assign bus.done_flag    = done_q;
    assign bus.active_flag  = active;
    assign bus.parity_error = perr_q;
    assign bus.stop_error   = serr_q;

endmodule

// File: tb/tb_uart_rx_sipo.sv
// Bench for uart_rx_sipo: serial driver pushes expected frames,
// monitor pops and compares on every done pulse.
module tb_uart_rx_sipo;

    // Scaled clock so every baud divisor is exact: 16, 8, 4, 2.
    localparam int unsigned CLK_HZ = 614400;
    localparam int BIT_CLK [4] = '{256, 128, 64, 32};

    typedef struct packed {
        logic [7:0] d;
        logic       pe;
        logic       se;
    } exp_t;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    uart_rx_sipo_if bus ();

    uart_rx_sipo #(.CLK_FREQ(CLK_HZ), .OVERSAMPLE(16)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    exp_t sbq[$];
    exp_t e;
    int n_tot = 0;
    int n_pass = 0;
    int n_done = 0;
    int n_exp = 0;
    int n_act = 0;
    int lat = 0;
    int a0, d0;
    logic act_q = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", nm, act, exp);
    endtask

    always @(negedge clock) begin
        if (reset_n && bus.active_flag && !act_q) n_act++;
        act_q <= bus.active_flag;
        if (bus.done_flag) begin
            n_done++;
            if (sbq.size() == 0) begin
                n_tot++;
                $display("FAIL unexpected_done: got data %0h want none",
                         bus.data_out);
            end else begin
                e = sbq.pop_front();
                chk("data_out", bus.data_out, e.d);
                chk("parity_error", bus.parity_error, e.pe);
                chk("stop_error", bus.stop_error, e.se);
            end
        end
    end

    task automatic idle(input int n);
        bus.data_rx = 1'b1;
        repeat (n) @(negedge clock);
    endtask

    task automatic send(input logic [7:0] b, input logic [1:0] br,
                        input logic [1:0] pt, input bit flip_par,
                        input bit stop_v, input bit toggle,
                        input int abort_bit);
        int bc;
        int nb;
        bit pen;
        logic pbit;
        logic [10:0] bits;
        bc = BIT_CLK[br];
        pen = (pt == 2'b01) || (pt == 2'b10);
        pbit = (^b) ^ (pt == 2'b01) ^ flip_par;
        nb = pen ? 11 : 10;
        bits = '1;
        bits[0] = 1'b0;
        bits[8:1] = b;
        if (pen) begin
            bits[9] = pbit;
            bits[10] = stop_v;
        end else begin
            bits[9] = stop_v;
        end
        bus.baud_rate = br;
        bus.parity_type = pt;
        if (abort_bit < 0) begin
            sbq.push_back(exp_t'{b, pen && flip_par, !stop_v});
            n_exp++;
        end
        for (int i = 0; i < nb; i++) begin
            bus.data_rx = bits[i];
            if (toggle && i == 3) bus.baud_rate = ~br;
            if (abort_bit >= 0 && i == abort_bit + 1) begin
                repeat (bc / 2) @(negedge clock);
                reset_n = 1'b0;
                repeat (3) @(negedge clock);
                bus.data_rx = 1'b1;
                reset_n = 1'b1;
                return;
            end
            repeat (bc) @(negedge clock);
        end
        bus.baud_rate = br;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] lb [6];
        logic [1:0] lp [4];
        lb = '{8'h00, 8'hFF, 8'h55, 8'hAA, 8'h01, 8'h80};
        lp = '{2'b00, 2'b01, 2'b10, 2'b11};
        bus.data_rx = 1'b1;
        bus.baud_rate = 2'b10;
        bus.parity_type = 2'b00;
        repeat (4) @(negedge clock);
        chk("rst_data_out", bus.data_out, 8'h00);
        chk("rst_done", bus.done_flag, 1'b0);
        chk("rst_active", bus.active_flag, 1'b0);
        chk("rst_parity_error", bus.parity_error, 1'b0);
        chk("rst_stop_error", bus.stop_error, 1'b0);
        reset_n = 1'b1;
        idle(10);

        // 9600, no parity, 0xA5, with start-to-done latency
        a0 = n_act;
        fork
            send(8'hA5, 2'b10, 2'b00, 1'b0, 1'b1, 1'b0, -1);
            begin
                lat = 0;
                while (!bus.done_flag && lat < 5000) begin
                    @(negedge clock);
                    lat++;
                end
            end
        join
        chk("latency_9600", (lat >= 608 && lat <= 616), 1'b1);
        idle(40);
        chk("active_pulses_a5", n_act - a0, 1);
        chk("active_after_a5", bus.active_flag, 1'b0);

        // 19200, even parity: good then bad parity bit
        send(8'h3C, 2'b11, 2'b10, 1'b0, 1'b1, 1'b0, -1);
        idle(20);
        send(8'h3C, 2'b11, 2'b10, 1'b1, 1'b1, 1'b0, -1);
        idle(20);

        // 4800, odd parity, then stop low and held low
        send(8'h00, 2'b01, 2'b01, 1'b0, 1'b1, 1'b0, -1);
        idle(20);
        send(8'h00, 2'b01, 2'b01, 1'b0, 1'b0, 1'b0, -1);
        a0 = n_act;
        repeat (600) @(negedge clock);
        chk("break_no_restart", n_act - a0, 0);
        chk("break_active", bus.active_flag, 1'b0);
        idle(100);

        // 2400 glitch: 3 ticks low
        a0 = n_act;
        d0 = n_done;
        bus.baud_rate = 2'b00;
        bus.parity_type = 2'b00;
        bus.data_rx = 1'b0;
        repeat (48) @(negedge clock);
        idle(600);
        chk("glitch_active_pulse", n_act - a0, 1);
        chk("glitch_no_done", n_done - d0, 0);
        chk("glitch_active_low", bus.active_flag, 1'b0);
        chk("glitch_data_kept", bus.data_out, 8'h00);
        chk("glitch_serr_kept", bus.stop_error, 1'b1);

        // Loopback-style frames at every baud code
        for (int br = 0; br < 4; br++) begin
            for (int k = 0; k < 6; k++) begin
                send(lb[k], 2'(br), lp[(br + k) % 4], 1'b0, 1'b1,
                     1'b0, -1);
                idle(20);
            end
        end
        send(8'h96, 2'b10, 2'b01, 1'b0, 1'b1, 1'b1, -1);
        idle(20);
        send(8'h4B, 2'b00, 2'b10, 1'b0, 1'b1, 1'b1, -1);
        idle(20);

        // Reset during data bit 4 of 0xFF, then 0x81
        d0 = n_done;
        send(8'hFF, 2'b10, 2'b00, 1'b0, 1'b1, 1'b0, 4);
        @(negedge clock);
        chk("abort_data_out", bus.data_out, 8'h00);
        chk("abort_active", bus.active_flag, 1'b0);
        chk("abort_perr", bus.parity_error, 1'b0);
        chk("abort_serr", bus.stop_error, 1'b0);
        idle(700);
        chk("abort_no_done", n_done - d0, 0);
        send(8'h81, 2'b10, 2'b00, 1'b0, 1'b1, 1'b0, -1);
        idle(200);

        chk("scoreboard_empty", sbq.size(), 0);
        chk("done_count", n_done, n_exp);
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
